fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 30 +++
 rtl/fq_fifo.sv | 97 +++++++++
 rtl/fetch_queue.sv | 114 +++++++++++
 tb/tb_fetch_queue.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared defaults, FSM encoding and entry layout for the fetch queue
package fetch_queue_pkg;

    localparam int          FQ_DEPTH    = 4;
    localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FQ_NOP      = 32'h0000_0000;

    // Two-state fetch FSM: normal fetching, or waiting to drop a stale response.
    localparam logic [0:0]  ST_RUN      = 1'b0;
    localparam logic [0:0]  ST_DISCARD  = 1'b1;

    // One queue entry: instruction word plus the fetch address of that word + 4.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fq_entry_t;

    localparam int FQ_ENTRY_W = $bits(fq_entry_t);

    // Force a fetch address onto a word boundary.
    function automatic logic [31:0] fq_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Sequential fetch address; wraps naturally at 2^32.
    function automatic logic [31:0] fq_next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// rtl/fq_fifo.sv - synchronous FIFO with flush, occupancy count and registered head
module fq_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WIDTH = FQ_ENTRY_W,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             head_valid_q, head_valid_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             do_push, do_pop;
    logic [AW-1:0]    rd_ptr_nxt;

    assign do_push    = push & ~flush;
    assign do_pop     = pop & ~flush & (count_q != '0);
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);

    // Next pointers, occupancy and the value the head register will hold after this edge.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        head_data_d = head_data_q;
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            head_data_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_nxt;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
            if (do_pop) begin
                if (count_q > CW'(1)) begin
                    head_data_d = mem_q[rd_ptr_nxt];
                end else if (do_push) begin
                    head_data_d = push_data;
                end else begin
                    head_data_d = '0;
                end
            end else if (count_q == '0) begin
                head_data_d = do_push ? push_data : '0;
            end
        end
        head_valid_d = (count_d != '0);
    end

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    assign count      = count_q;
    assign head_valid = head_valid_q;
    assign head_data  = head_data_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch unit with redirect handling and a prefetch queue
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = FQ_DEPTH,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   target_q, target_d;

    logic          ack;
    logic          fifo_push, fifo_pop, fifo_flush;
    logic [CW-1:0] fifo_count;
    logic          head_valid;
    fq_entry_t     head_entry;
    fq_entry_t     push_entry;

    // A request is live while stale data is owed (DISCARD) or while the queue has room.
    assign mem_req  = ~reset & ((state_q == ST_DISCARD) | (fifo_count < CW'(DEPTH)));
    assign mem_addr = fetch_pc_q;
    assign ack      = mem_req & mem_ack;

    assign push_entry.instr = mem_rdata;
    assign push_entry.pc4   = fq_next_pc(fetch_pc_q);

    // Fetch FSM: decides push, flush and the next fetch address; redirect outranks push and pop.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        fifo_push  = 1'b0;
        fifo_flush = redirect;
        fifo_pop   = out_valid & ~stall & ~redirect;
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    if (!mem_req || mem_ack) begin
                        fetch_pc_d = fq_align(redirect_pc);
                    end else begin
                        target_d = fq_align(redirect_pc);
                        state_d  = ST_DISCARD;
                    end
                end else if (ack) begin
                    fifo_push  = 1'b1;
                    fetch_pc_d = fq_next_pc(fetch_pc_q);
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    target_d = fq_align(redirect_pc);
                end
                if (ack) begin
                    fetch_pc_d = redirect ? fq_align(redirect_pc) : target_q;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state, fetch address and pending redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= fq_align(RESET_PC);
            target_q   <= fq_align(RESET_PC);
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FQ_ENTRY_W),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (fifo_flush),
        .push       (fifo_push),
        .push_data  (push_entry),
        .pop        (fifo_pop),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head_data  (head_entry)
    );

    // Outputs come only from the registered head, so mem_rdata never reaches them combinationally.
    assign out_valid = head_valid & ~reset;
    assign out_instr = out_valid ? head_entry.instr : FQ_NOP;
    assign out_pc4   = out_valid ? head_entry.pc4   : FQ_NOP;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-based reference model
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {instr, pc4}, fetch address, discard flag and target.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    bit          m_disc;
    bit          m_rst;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc4     (out_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit          exp_req;
        bit          exp_valid;
        logic [63:0] head;
        exp_req   = !m_rst && (m_disc || mq.size() < DEPTH);
        exp_valid = !m_rst && mq.size() > 0;
        head      = exp_valid ? mq[0] : 64'h0;
        chk("mem_req", {31'h0, mem_req}, {31'h0, exp_req});
        if (exp_req) chk("mem_addr", mem_addr, m_pc);
        chk("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
        chk("out_instr", out_instr, head[63:32]);
        chk("out_pc4", out_pc4, head[31:0]);
    endtask

    // One cycle: check outputs, drive inputs, advance the model, cross the rising edge.
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                        input bit st, input bit ack);
        bit          req;
        bit          a;
        bit          popv;
        logic [31:0] tgt;
        check_outputs();
        reset       = rst;
        redirect    = redir;
        redirect_pc = rpc;
        stall       = st;
        req         = !rst && (m_disc || mq.size() < DEPTH);
        a           = req && ack;
        mem_ack     = a;
        mem_rdata   = a ? word(mem_addr) : $urandom();
        tgt         = rpc & 32'hFFFF_FFFC;
        popv        = !rst && mq.size() > 0 && !st;
        if (rst) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_disc = 1'b0;
        end else if (!m_disc) begin
            if (redir) begin
                mq.delete();
                if (!req || a) m_pc = tgt;
                else begin
                    m_tgt  = tgt;
                    m_disc = 1'b1;
                end
            end else begin
                if (popv) void'(mq.pop_front());
                if (a) begin
                    mq.push_back({word(m_pc), m_pc + 32'd4});
                    m_pc = m_pc + 32'd4;
                end
            end
        end else begin
            if (redir) begin
                m_tgt = tgt;
                mq.delete();
            end
            if (a) begin
                m_pc   = m_tgt;
                m_disc = 1'b0;
            end
        end
        m_rst = rst;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        m_pc = RESET_PC; m_tgt = RESET_PC; m_disc = 1'b0; m_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset state, then streaming with same-cycle acks
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Fill to DEPTH under stall, drain, then resume at 0x10
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("full_no_req", {31'h0, mem_req}, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("resume_addr", mem_addr, 32'h10);
        chk("resume_req", {31'h0, mem_req}, 32'h1);

        // Redirect while 0x8 is outstanding: hold 0x8, drop its data, refetch 0x100
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        chk("disc_hold_addr", mem_addr, 32'h8);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("disc_drop_valid", {31'h0, out_valid}, 32'h0);
        chk("disc_new_addr", mem_addr, 32'h100);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("disc_first_pc4", out_pc4, 32'h104);

        // Redirect coinciding with pop and ack
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
        chk("rd_pop_ack_valid", {31'h0, out_valid}, 32'h0);
        chk("rd_pop_ack_instr", out_instr, 32'h0);
        chk("rd_pop_ack_addr", mem_addr, 32'h40);

        // Address wrap at the top of the space
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_pc4", out_pc4, 32'h0);
        chk("wrap_addr", mem_addr, 32'h0);

        // Reset with three entries queued and a request pending
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_mid_req", {31'h0, mem_req}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_release_addr", mem_addr, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom();
            step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, rpc,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
